// File: rtl/zx_mem_pkg.sv
// Shared types and constants for the Spectrum SDRAM byte-port arbiter.
package zx_mem_pkg;

    localparam int ZX_MEM_AW = 25;
    localparam int ZX_MEM_DW = 8;

    localparam int CH_DMA    = 0;
    localparam int CH_TAPE   = 1;
    localparam int CH_FDD    = 2;
    localparam int CH_DIVMMC = 3;
    localparam int CH_CPU    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zx_mem_arbiter_if.sv
// Requestor-side handshake plus SDRAM byte-port signals of the arbiter.
// mem_dout belongs to the memory side but is driven by whoever models the SDRAM.
interface zx_mem_arbiter_if import zx_mem_pkg::*; #(
    parameter int NCH = 5,
    parameter int AW  = ZX_MEM_AW,
    parameter int DW  = ZX_MEM_DW
) ();
    localparam int GW = idx_width(NCH);

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [DW-1:0]     mem_dout;

    modport master (
        output req, we, addr, wdata, mem_dout,
        input  ack, rdata, busy, grant_id, mem_addr, mem_din, mem_we, mem_rd
    );

    modport slave (
        input  req, we, addr, wdata, mem_dout,
        output ack, rdata, busy, grant_id, mem_addr, mem_din, mem_we, mem_rd
    );

endinterface

// File: rtl/zx_arb_pick.sv
// Combinational winner select; channel 0 always wins when requesting.
// ZX_ARB_RR_EN: channels 1..NCH-1 rotate from the rr pointer instead of fixed order.
module zx_arb_pick import zx_mem_pkg::*; #(
    parameter int NCH = 5,
    parameter int GW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] i_req,
`ifdef ZX_ARB_RR_EN
    input  logic [GW-1:0]  i_rr_ptr,
`endif
    output logic [GW-1:0]  o_winner,
    output logic           o_valid
);

`ifdef ZX_ARB_RR_EN
    logic [GW-1:0] w_start;

    // A pointer of 0 (reset value) starts the rotation at channel 1.
    assign w_start = (i_rr_ptr == '0) ? GW'(1) : i_rr_ptr;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        if (i_req[0]) begin
            o_valid = 1'b1;
        end else begin
            for (int i = 1; i < NCH; i++) begin
                if (!o_valid && i_req[i] && (i >= int'(w_start))) begin
                    o_winner = GW'(i);
                    o_valid  = 1'b1;
                end
            end
            for (int i = 1; i < NCH; i++) begin
                if (!o_valid && i_req[i] && (i < int'(w_start))) begin
                    o_winner = GW'(i);
                    o_valid  = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!o_valid && i_req[i]) begin
                o_winner = GW'(i);
                o_valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/zx_mem_arbiter.sv
// Registered NCH-way arbiter onto the shared SDRAM byte port; ZX_ARB_RR_EN enables round-robin.
// IDLE: wait for req | ACCESS: strobes held ACC_CYC cycles | DONE: one-cycle ack
module zx_mem_arbiter import zx_mem_pkg::*; #(
    parameter int NCH     = 5,
    parameter int AW      = ZX_MEM_AW,
    parameter int DW      = ZX_MEM_DW,
    parameter int ACC_CYC = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    zx_mem_arbiter_if.slave bus
);
    localparam int GW = idx_width(NCH);

    arb_state_t     r_state, w_state_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic           r_wr, w_wr_nxt;
    logic [NCH-1:0] r_ack, w_ack_nxt;
    logic [DW-1:0]  r_rdata, w_rdata_nxt;
    logic [GW-1:0]  r_grant, w_grant_nxt;
    logic [AW-1:0]  r_mem_addr, w_addr_nxt;
    logic [DW-1:0]  r_mem_din, w_din_nxt;
    logic           r_mem_we, w_we_nxt;
    logic           r_mem_rd, w_rd_nxt;
    logic [GW-1:0]  w_pick;
    logic           w_pick_valid;
`ifdef ZX_ARB_RR_EN
    logic [GW-1:0]  r_rr, w_rr_nxt;
`endif

    zx_arb_pick #(.NCH(NCH), .GW(GW)) u_pick (
        .i_req    (bus.req),
`ifdef ZX_ARB_RR_EN
        .i_rr_ptr (r_rr),
`endif
        .o_winner (w_pick),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_grant    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_rd   <= 1'b0;
`ifdef ZX_ARB_RR_EN
            r_rr       <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr       <= w_wr_nxt;
            r_ack      <= w_ack_nxt;
            r_rdata    <= w_rdata_nxt;
            r_grant    <= w_grant_nxt;
            r_mem_addr <= w_addr_nxt;
            r_mem_din  <= w_din_nxt;
            r_mem_we   <= w_we_nxt;
            r_mem_rd   <= w_rd_nxt;
`ifdef ZX_ARB_RR_EN
            r_rr       <= w_rr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_ack_nxt   = '0;
        w_rdata_nxt = r_rdata;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_mem_addr;
        w_din_nxt   = r_mem_din;
        w_we_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
`ifdef ZX_ARB_RR_EN
        w_rr_nxt    = r_rr;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = 4'(ACC_CYC - 1);
                    w_grant_nxt = w_pick;
                    w_wr_nxt    = bus.we[w_pick];
                    w_addr_nxt  = bus.addr[int'(w_pick)*AW +: AW];
                    w_din_nxt   = bus.wdata[int'(w_pick)*DW +: DW];
                    w_we_nxt    = bus.we[w_pick];
                    w_rd_nxt    = ~bus.we[w_pick];
`ifdef ZX_ARB_RR_EN
                    if (w_pick != '0)
                        w_rr_nxt = (w_pick == GW'(NCH - 1)) ? GW'(1) : w_pick + GW'(1);
`endif
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt        = DONE;
                    w_ack_nxt[r_grant] = 1'b1;
                    if (!r_wr)
                        w_rdata_nxt = bus.mem_dout;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    w_we_nxt  = r_wr;
                    w_rd_nxt  = ~r_wr;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = (r_state != IDLE);
    assign bus.grant_id = r_grant;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_rd   = r_mem_rd;

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Randomised bench for zx_mem_arbiter against a transaction-schedule reference model.
// Two instances: 5 channels / 4-cycle access, and 2 channels / 1-cycle access.
module tb_zx_mem_arbiter;

    localparam int NA = 5;
    localparam int AA = 4;
    localparam int NB = 2;
    localparam int AB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zx_mem_arbiter_if #(.NCH(NA)) if_a ();
    zx_mem_arbiter_if #(.NCH(NB)) if_b ();

    zx_mem_arbiter #(.NCH(NA), .ACC_CYC(AA)) u_dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a));
    zx_mem_arbiter #(.NCH(NB), .ACC_CYC(AB)) u_dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b));

    // requestor-side stimulus, [dut][channel]
    logic [4:0]  s_req   [2];
    logic [4:0]  s_we    [2];
    logic [4:0]  s_held  [2];
    logic [4:0]  s_rmask [2];
    logic [24:0] s_addr  [2][5];
    logic [7:0]  s_wdata [2][5];
    logic [7:0]  s_dout  [2];
    bit          s_rbus  [2];
    bit          s_rdonly[2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // one access = sample edge t0, strobes in cycles t0..t0+acc-1, ack in cycle t0+acc
    typedef struct {
        bit          act;
        int          t0;
        int          next_ok;
        int          win;
        bit          wr;
        logic [24:0] addr;
        logic [7:0]  din;
        logic [7:0]  rdata;
        int          gid;
        int          ptr;
    } mdl_t;
    mdl_t m[2];

    function automatic int nch_of(input int d);
        return (d == 0) ? NA : NB;
    endfunction

    function automatic int acc_of(input int d);
        return (d == 0) ? AA : AB;
    endfunction

    function automatic int pick(input logic [4:0] req, input int nch, input int ptr);
        int start;
        int ch;
`ifdef ZX_ARB_RR_EN
        if (req[0]) return 0;
        start = (ptr == 0) ? 1 : ptr;
        for (int off = 0; off < nch - 1; off++) begin
            ch = (start - 1 + off) % (nch - 1) + 1;
            if (((req >> ch) & 5'd1) != 5'd0) return ch;
        end
`else
        start = ptr;
        ch    = start;
        for (int i = 0; i < nch; i++)
            if (((req >> i) & 5'd1) != 5'd0) return i;
`endif
        return 0;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic mdl_edge(input int d);
        int nch;
        int acc;
        int w;
        nch = nch_of(d);
        acc = acc_of(d);
        if (rst) begin
            m[d].act     = 1'b0;
            m[d].t0      = -100;
            m[d].next_ok = cyc + 1;
            m[d].win     = 0;
            m[d].wr      = 1'b0;
            m[d].addr    = '0;
            m[d].din     = '0;
            m[d].rdata   = '0;
            m[d].gid     = 0;
            m[d].ptr     = 0;
            return;
        end
        if (m[d].act && cyc == m[d].t0 + acc && !m[d].wr)
            m[d].rdata = s_dout[d];
        if (cyc >= m[d].next_ok && s_req[d] != 5'd0) begin
            w            = pick(s_req[d], nch, m[d].ptr);
            m[d].act     = 1'b1;
            m[d].t0      = cyc;
            m[d].win     = w;
            m[d].gid     = w;
            m[d].wr      = s_we[d][w];
            m[d].addr    = s_addr[d][w];
            m[d].din     = s_wdata[d][w];
            m[d].next_ok = cyc + acc + 2;
`ifdef ZX_ARB_RR_EN
            if (w != 0) m[d].ptr = (w == nch - 1) ? 1 : w + 1;
`endif
        end
    endtask

    task automatic chk_dut(input int d);
        int          acc;
        bit          in_acc;
        bit          in_busy;
        logic [4:0]  e_ack;
        logic [4:0]  o_ack;
        logic [7:0]  o_rdata;
        logic [7:0]  o_din;
        logic [24:0] o_addr;
        logic [2:0]  o_gid;
        logic        o_busy;
        logic        o_we;
        logic        o_rd;
        string       p;
        acc     = acc_of(d);
        in_acc  = m[d].act && cyc >= m[d].t0 && cyc <= m[d].t0 + acc - 1;
        in_busy = m[d].act && cyc >= m[d].t0 && cyc <= m[d].t0 + acc;
        e_ack   = (m[d].act && cyc == m[d].t0 + acc) ? (5'd1 << m[d].win) : 5'd0;
        if (d == 0) begin
            p = "a_";
            o_ack = if_a.ack; o_rdata = if_a.rdata; o_din = if_a.mem_din;
            o_addr = if_a.mem_addr; o_gid = if_a.grant_id; o_busy = if_a.busy;
            o_we = if_a.mem_we; o_rd = if_a.mem_rd;
        end else begin
            p = "b_";
            o_ack = {3'b0, if_b.ack}; o_rdata = if_b.rdata; o_din = if_b.mem_din;
            o_addr = if_b.mem_addr; o_gid = {2'b0, if_b.grant_id}; o_busy = if_b.busy;
            o_we = if_b.mem_we; o_rd = if_b.mem_rd;
        end
        check_val({p, "ack"},      64'(o_ack),   64'(e_ack));
        check_val({p, "rdata"},    64'(o_rdata), 64'(m[d].rdata));
        check_val({p, "busy"},     64'(o_busy),  64'(in_busy));
        check_val({p, "grant_id"}, 64'(o_gid),   64'(m[d].gid));
        check_val({p, "mem_addr"}, 64'(o_addr),  64'(m[d].addr));
        check_val({p, "mem_din"},  64'(o_din),   64'(m[d].din));
        check_val({p, "mem_we"},   64'(o_we),    64'(in_acc && m[d].wr));
        check_val({p, "mem_rd"},   64'(o_rd),    64'(in_acc && !m[d].wr));
    endtask

    // a requestor holds req until its ack, then drops or re-requests
    task automatic auto_req(input int d);
        logic [4:0] ackv;
        ackv = (d == 0) ? if_a.ack : {3'b0, if_b.ack};
        for (int i = 0; i < nch_of(d); i++) begin
            if (s_held[d][i])
                s_req[d][i] = 1'b1;
            else if (s_req[d][i] && !ackv[i])
                s_req[d][i] = 1'b1;
            else
                s_req[d][i] = s_rmask[d][i] && ($urandom_range(0, 3) == 0);
            if (s_rbus[d]) begin
                s_addr[d][i]  = 25'($urandom);
                s_wdata[d][i] = 8'($urandom);
                s_we[d][i]    = s_rdonly[d] ? 1'b0 : 1'($urandom);
            end
        end
        if (s_rbus[d]) s_dout[d] = 8'($urandom);
    endtask

    task automatic drive();
        if_a.req      = s_req[0];
        if_a.we       = s_we[0];
        if_a.mem_dout = s_dout[0];
        for (int i = 0; i < NA; i++) begin
            if_a.addr[i*25 +: 25] = s_addr[0][i];
            if_a.wdata[i*8 +: 8]  = s_wdata[0][i];
        end
        if_b.req      = s_req[1][1:0];
        if_b.we       = s_we[1][1:0];
        if_b.mem_dout = s_dout[1];
        for (int i = 0; i < NB; i++) begin
            if_b.addr[i*25 +: 25] = s_addr[1][i];
            if_b.wdata[i*8 +: 8]  = s_wdata[1][i];
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        cyc++;
        mdl_edge(0);
        mdl_edge(1);
        @(negedge clk);
        chk_dut(0);
        chk_dut(1);
        auto_req(0);
        auto_req(1);
    endtask

    initial begin
        int  cs;
        bit  ok;
        for (int d = 0; d < 2; d++) begin
            s_req[d] = '0; s_we[d] = '0; s_held[d] = '0; s_rmask[d] = '0;
            s_dout[d] = '0; s_rbus[d] = 1'b0; s_rdonly[d] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                s_addr[d][i] = '0;
                s_wdata[d][i] = '0;
            end
        end
        drive();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // single CPU read
        s_req[0][4] = 1'b1; s_we[0][4] = 1'b0;
        s_addr[0][4] = 25'h0A000; s_dout[0] = 8'h5A;
        repeat (10) step();

        // held requests under fixed priority; small instance does back-to-back ch1 reads
        s_rbus[0] = 1'b1;
        s_held[0] = 5'b10101;
        s_held[1] = 5'b00010; s_rbus[1] = 1'b1; s_rdonly[1] = 1'b1;
        repeat (30) step();
        s_held[0] = 5'b10100;
        repeat (30) step();
        s_held[0] = 5'b10000;
        repeat (20) step();
        s_held[0] = 5'b00000;
        repeat (8) step();

        // write on FDD channel with wdata disturbed mid-access
        s_rbus[0] = 1'b0;
        s_we[0][2] = 1'b1; s_addr[0][2] = 25'h200010; s_wdata[0][2] = 8'hC3;
        s_req[0][2] = 1'b1;
        cs = cyc;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (m[0].act && m[0].win == 2 && m[0].t0 > cs) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_val("wr_grant_wait", 64'(ok), 64'd1);
        s_wdata[0][2] = 8'hFF;
        repeat (8) step();

        // reset during the second access cycle
        s_we[0][1] = 1'b0; s_addr[0][1] = 25'h01234; s_req[0][1] = 1'b1;
        cs = cyc;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (m[0].act && m[0].win == 1 && m[0].t0 > cs && cyc == m[0].t0 + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_val("rst_sync_wait", 64'(ok), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_req[0][1] = 1'b0;
        repeat (3) step();
        s_we[0][3] = 1'b0; s_addr[0][3] = 25'h1FFFFFF; s_dout[0] = 8'hA5;
        s_req[0][3] = 1'b1;
        repeat (10) step();

`ifdef ZX_ARB_RR_EN
        s_rbus[0] = 1'b1;
        s_held[0] = 5'b11110;
        repeat (40) step();
        s_req[0][0] = 1'b1;
        repeat (30) step();
        s_held[0] = 5'b00000;
        repeat (8) step();
`endif

        // free-running random traffic with occasional resets
        s_rdonly[1] = 1'b0; s_held[1] = 5'b00000; s_rmask[1] = 5'b00011;
        s_rbus[0] = 1'b1; s_rmask[0] = 5'b11111;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        s_rmask[0] = '0; s_rmask[1] = '0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/zx_mem_arbiter.md
Name: zx_mem_arbiter

Overview:
Parametrised, registered arbiter that multiplexes NCH requestors onto the single shared SDRAM byte port (sram) of the Spectrum host board. Requestors are DMA loader, tape, FDD buffer, DivMMC and CPU. It replaces the ad-hoc combinational ram_addr/ram_din/ram_we/ram_rd muxing with a request/acknowledge handshake and a fixed-length access sequencer. Each access latches its address and data, so requestors may change their buses once the request is taken.

Parameters:
NCH, 5, number of requestor channels; channel 0 = highest fixed priority (DMA)
AW, 25, address width
DW, 8, data width
ACC_CYC, 4, clk cycles mem_rd/mem_we held per access; legal range 1..15

Ports:
clk  in  1  system clock (clk_sys, 28 MHz)
reset  in  1  synchronous, active-high
req  in  NCH  per-channel request level, held until ack
we  in  NCH  per-channel write (1) / read (0), valid with req
addr  in  NCH*AW  packed per-channel addresses, channel i at [i*AW +: AW]
wdata  in  NCH*DW  packed per-channel write data
ack  out  NCH  one-hot, one-cycle completion pulse
rdata  out  DW  read data of the last completed access, valid with ack
busy  out  1  access in progress (state != IDLE)
grant_id  out  $clog2(NCH)  channel currently or last served
mem_addr  out  AW  to sram addr
mem_din  out  DW  to sram din
mem_we  out  1  to sram we
mem_rd  out  1  to sram rd
mem_dout  in  DW  from sram dout

Behaviour:
- Single clock, clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, ack=0, rdata=0, busy=0, grant_id=0, mem_addr=0, mem_din=0, mem_we=0, mem_rd=0, rr pointer=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, any req set:
  - pick a winner (see arbitration);
  - latch addr[winner], wdata[winner] and we[winner] into mem_addr / mem_din / the write flag;
  - grant_id := winner; cnt := ACC_CYC-1; go to ACCESS.
- IDLE, no req set: stay; all mem strobes 0.
- ACCESS:
  - mem_we = latched write flag; mem_rd = ~latched write flag; both registered outputs.
  - cnt decrements each cycle.
  - At cnt==0: if a read, rdata := mem_dout; go to DONE.
- DONE: ack[grant_id]=1 for exactly one cycle; mem_we=mem_rd=0; go to IDLE.
- Timing: the req sample edge to the ack cycle is ACC_CYC+1 cycles. Back-to-back issue rate is one access per ACC_CYC+2 cycles.
- Requestor rule: req must be deasserted, or re-presented as a new access, by the edge that ends its ack cycle. The arbiter samples req again in the IDLE cycle that follows, so a held req is a new access.
- Writes leave rdata unchanged.
- Fixed priority: the lowest-index requesting channel wins.
- req dropped mid-access: the access completes and ack is still pulsed. Nothing is aborted.
- addr/wdata changed mid-access: ignored, because the values are latched.
- Reset mid-access: next cycle is IDLE with strobes 0 and no ack. The interrupted access is lost.
- Width: addr and wdata are sliced as [i*AW +: AW] and [i*DW +: DW]. grant_id has width max(1,$clog2(NCH)).
- cnt is 4 bits. ACC_CYC=1 gives a single ACCESS cycle.

Optional Feature:
ZX_ARB_RR_EN
- Defined: channel 0 keeps absolute priority. Channels 1..NCH-1 are served round-robin.
  - The search starts at the rr pointer. After each non-zero grant, rr := grant_id+1, wrapping NCH-1 -> 1.
  - The pointer is not updated on channel-0 grants.
- Undefined: pure fixed priority. No rr register exists.

Decomposition:
- Package zx_mem_pkg: arb_state_t enum (IDLE, ACCESS, DONE), ZX_MEM_AW=25, ZX_MEM_DW=8, and channel index constants CH_DMA=0, CH_TAPE=1, CH_FDD=2, CH_DIVMMC=3, CH_CPU=4.
- One sub-module: zx_arb_pick. Combinational winner select from the req vector and rr pointer; outputs winner index and a valid flag. The RR logic sits inside it, under the macro.

Test Plan:
1. Reset, then req[4]=1 read at addr 0x0A000 with mem_dout=0x5A → strobe and ack timing:
   - mem_rd high exactly 4 cycles;
   - ack=5'b10000 at cycle 5 after the sample edge;
   - rdata=0x5A; grant_id=4.
2. req=5'b10101 held every cycle (fixed priority) → grants 0,0,0…, with ack[0] every 6 cycles. Drop req[0] → grant order 2,2,…; drop req[2] → grant order 4.
3. Write on channel 2 (we=1, addr 0x200010, wdata 0xC3); change wdata to 0xFF during ACCESS → mem_din stays 0xC3 for 4 cycles; rdata unchanged.
4. Assert reset in the 2nd ACCESS cycle → mem_we/mem_rd low next cycle, no ack, busy=0; a later request is served normally.
5. ZX_ARB_RR_EN, req=5'b11110 held → grant order 1,2,3,4,1. Assert req[0] → it wins next; the following grant resumes the RR sequence.
6. ACC_CYC=1, NCH=2, back-to-back reads on ch1 → ack every 3 cycles; mem_rd pulse 1 cycle wide.
